// File: rtl/lb_uart_rx_buffer.sv
// Receive FIFO behind the UART Rx core: captures {ferr, perr, data} on each rx_done rising edge.
// Optional registered level interrupt enabled by defining LB_UART_RX_BUF_IRQ_EN.
module lb_uart_rx_buffer #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AW        = 4,
    parameter int unsigned IRQ_LEVEL = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_done,
    input  logic          rx_perr,
    input  logic          rx_ferr,
    input  logic          rd,
    input  logic          clr_ovr,
    output logic [7:0]    dout,
    output logic          dout_perr,
    output logic          dout_ferr,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overrun,
    output logic          irq
);

    if (DEPTH != (1 << AW) || DEPTH < 2) begin : g_bad_depth
        $error("lb_uart_rx_buffer: DEPTH must be a power of 2 >= 2 and equal 2**AW");
    end
    if (IRQ_LEVEL < 1 || IRQ_LEVEL > DEPTH) begin : g_bad_irq_level
        $error("lb_uart_rx_buffer: IRQ_LEVEL must lie in 1..DEPTH");
    end

    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   count_q, count_d;
    logic          done_q;
    logic          ovr_q, ovr_d;
    logic          push, pop, wr_en, ovr_set;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == (AW+1)'(DEPTH));
        push    = rx_done & ~done_q;
        pop     = rd & ~empty;
        // A simultaneous pop frees the slot, so a push at full is still accepted.
        wr_en   = push & (~full | pop);
        ovr_set = push & full & ~pop;

        wp_d    = wr_en ? wp_q + 1'b1 : wp_q;
        rp_d    = pop   ? rp_q + 1'b1 : rp_q;
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        ovr_d = ovr_q;
        if (ovr_set)      ovr_d = 1'b1;
        else if (clr_ovr) ovr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
            // Held high so a done level already present at release is not taken as a new byte.
            done_q  <= 1'b1;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
            done_q  <= rx_done;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            mem_q[wp_q] <= {rx_ferr, rx_perr, rx_data};
        end
    end

    always_comb begin
        dout      = mem_q[rp_q][7:0];
        dout_perr = mem_q[rp_q][8];
        dout_ferr = mem_q[rp_q][9];
        count     = count_q;
        overrun   = ovr_q;
    end

`ifdef LB_UART_RX_BUF_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (count_q >= (AW+1)'(IRQ_LEVEL)) | ovr_q;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_lb_uart_rx_buffer.sv
// Directed scoreboard bench for lb_uart_rx_buffer; irq expectations follow LB_UART_RX_BUF_IRQ_EN.
module tb_lb_uart_rx_buffer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned LVL   = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   rx_data;
    logic         rx_done, rx_perr, rx_ferr, rd, clr_ovr;
    logic [7:0]   dout;
    logic         dout_perr, dout_ferr, empty, full, overrun, irq;
    logic [AW:0]  count;

    lb_uart_rx_buffer #(.DEPTH(DEPTH), .AW(AW), .IRQ_LEVEL(LVL)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
        .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rd(rd), .clr_ovr(clr_ovr),
        .dout(dout), .dout_perr(dout_perr), .dout_ferr(dout_ferr),
        .empty(empty), .full(full), .count(count), .overrun(overrun), .irq(irq)
    );

    always #5 clk = ~clk;

    logic [9:0] sb[$];
    logic       m_ovr;
    int         passed = 0;
    int         total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic exp_irq();
`ifdef LB_UART_RX_BUF_IRQ_EN
        return (sb.size() >= LVL) || m_ovr;
`else
        return 1'b0;
`endif
    endfunction

    task automatic status(input string tag);
        check({tag, ".count"},   32'(count),   32'(sb.size()));
        check({tag, ".empty"},   32'(empty),   32'(sb.size() == 0));
        check({tag, ".full"},    32'(full),    32'(sb.size() == DEPTH));
        check({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
        check({tag, ".irq"},     32'(irq),     32'(exp_irq()));
    endtask

    task automatic push(input logic [7:0] d, input logic pe, input logic fe, input int hold);
        @(negedge clk);
        rx_data = d; rx_perr = pe; rx_ferr = fe; rx_done = 1'b1;
        if (sb.size() < DEPTH) sb.push_back({fe, pe, d});
        else m_ovr = 1'b1;
        @(negedge clk);
        rx_data = ~d; rx_perr = ~pe; rx_ferr = ~fe;
        for (int i = 1; i < hold; i++) @(negedge clk);
        rx_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop(input string tag);
        logic [9:0] e;
        @(negedge clk);
        if (sb.size() == 0) begin
            check({tag, ".sb_nonempty"}, 32'(0), 32'(1));
        end else begin
            e = sb.pop_front();
            check({tag, ".dout"}, 32'(dout),      32'(e[7:0]));
            check({tag, ".perr"}, 32'(dout_perr), 32'(e[8]));
            check({tag, ".ferr"}, 32'(dout_ferr), 32'(e[9]));
        end
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_ovr = 1'b1;
        m_ovr = 1'b0;
        @(negedge clk);
        clr_ovr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] e;
        reset = 1'b0; rx_data = '0; rx_done = 1'b0; rx_perr = 1'b0; rx_ferr = 1'b0;
        rd = 1'b0; clr_ovr = 1'b0; m_ovr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        status("reset");

        push(8'h41, 1'b0, 1'b0, 5);
        status("long_done");
        check("long_done.dout", 32'(dout), 32'h41);
        pop("pop41");
        status("after_pop41");

        push(8'h55, 1'b1, 1'b0, 1);
        push(8'h7E, 1'b0, 1'b1, 2);
        status("two_flags");
        pop("pop55");
        pop("pop7E");
        status("flags_drained");

        for (int i = 0; i < 16; i++) push(8'(i), i[0], i[1], 1);
        status("filled");
        push(8'h10, 1'b0, 1'b0, 1);
        status("dropped");
        for (int i = 0; i < 16; i++) pop("drain_fill");
        status("drained_ovr_sticky");
        pulse_clr();
        status("ovr_cleared");

        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i), 1'b0, 1'b0, 1);
        @(negedge clk);
        e = sb.pop_front();
        check("pushpop.head", 32'(dout), 32'(e[7:0]));
        rx_data = 8'hAA; rx_perr = 1'b0; rx_ferr = 1'b0; rx_done = 1'b1; rd = 1'b1;
        sb.push_back({2'b00, 8'hAA});
        @(negedge clk);
        rx_done = 1'b0; rd = 1'b0;
        @(negedge clk);
        status("pushpop_full");

        @(negedge clk);
        rx_data = 8'hBB; rx_done = 1'b1; clr_ovr = 1'b1;
        m_ovr = 1'b1;
        @(negedge clk);
        rx_done = 1'b0; clr_ovr = 1'b0;
        @(negedge clk);
        status("set_beats_clear");
        pulse_clr();
        for (int i = 0; i < 16; i++) pop("drain_aa");
        status("aa_drained");

        pop_empty: begin
            @(negedge clk);
            rd = 1'b1;
            @(negedge clk);
            rd = 1'b0;
            @(negedge clk);
        end
        status("rd_empty");
        push(8'h99, 1'b1, 1'b1, 1);
        pop("after_rd_empty");

        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i), 1'b0, 1'b0, 1);
        status("five");
        @(negedge clk);
        rx_data = 8'hEE; rx_done = 1'b1; reset = 1'b0;
        sb.delete(); m_ovr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        status("reset_done_high");
        rx_done = 1'b0;
        @(negedge clk);
        status("reset_done_low");
        push(8'h3C, 1'b0, 1'b1, 1);
        pop("after_reset");

        for (int i = 0; i < 3; i++) push(8'h80 + 8'(i), 1'b0, 1'b0, 1);
        status("irq_three");
        push(8'h83, 1'b0, 1'b0, 1);
        status("irq_four");
        pop("irq_pop");
        status("irq_back_three");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
